// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared constants for the WM8731 codec configuration sequencer
// Purpose: codec I2C address, power-up register table and sequencer state codes.
// Ports: none (package).
package codec_cfg_pkg;

  localparam logic [7:0] WM8731_ADDR = 8'h34;

  localparam int N_TABLE = 11;

  // {reg[6:0], val[8:0]} words, written in order after reset.
  // First entry resets the codec, last entry activates the digital interface.
  localparam logic [15:0] WM8731_TABLE [N_TABLE] = '{
    16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
    16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201
  };

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_RETRY = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERROR = 3'd7;

endpackage

// File: rtl/codec_cfg_rom.sv
// rtl/codec_cfg_rom.sv - combinational step-to-word lookup of the codec register table
// Purpose: returns the table word for a step index; 0 beyond the end of the table.
// Ports: step [3:0] in - table index; word [15:0] out - register word.
module codec_cfg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  step,
  output logic [15:0] word
);

  always_comb begin
    word = 16'h0000;
    if (int'(step) < N_TABLE) begin
      word = WM8731_TABLE[step];
    end
  end

endmodule

// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - audio codec register-table sequencer in front of the I2C write controller
// Purpose: after reset or cfg_start writes every table word to the codec, then serves
//   single runtime writes (usr_req/usr_data/usr_ack) to the same I2C controller.
// Ports: i2c_clock_50, rst_i (sync, active-high); cfg_start, usr_req, usr_data, usr_ack;
//   i2c_busy, i2c_done, i2c_addr, i2c_data, i2c_send_flag (controller side);
//   cfg_busy, cfg_done, cfg_error, cfg_step (status).
// Build option: CODEC_CFG_RETRY_EN enables NACK retries up to MAX_RETRY per write.
module codec_cfg_seq
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = WM8731_ADDR,
  parameter int          N_REGS     = 11,  // one entry per table word
  parameter int          MAX_RETRY  = 3,
  parameter logic [19:0] TIMEOUT    = 20'd1_000_000,
  parameter int          GAP_CYCLES = 512
) (
  input  logic        i2c_clock_50,
  input  logic        rst_i,
  input  logic        cfg_start,
  input  logic        usr_req,
  input  logic [15:0] usr_data,
  output logic        usr_ack,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  output logic [7:0]  i2c_addr,
  output logic [15:0] i2c_data,
  output logic        i2c_send_flag,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cfg_step
);

  localparam logic [3:0]  LAST_STEP = 4'(N_REGS - 1);
  localparam logic [19:0] GAP_LAST  = 20'(GAP_CYCLES - 1);
  localparam logic [19:0] TOUT_LAST = TIMEOUT - 20'd1;

  logic [2:0]  state;
  logic [3:0]  step;
  logic [19:0] timer;     // timeout count in REQ/WAIT, gap count in GAP
  logic        busy_q;
  logic        seen_done;
  logic        usr_txn;   // current write belongs to the runtime requester
`ifdef CODEC_CFG_RETRY_EN
  logic [3:0]  retry;
  logic        resend;    // GAP must reload the same word rather than advance
`endif

  logic [15:0] rom_word;
  logic        busy_fall;
  logic        timed_out;
  logic        exhausted;
  logic        fail_evt;

  codec_cfg_rom u_rom (
    .step (step),
    .word (rom_word)
  );

  assign i2c_addr = DEV_ADDR;
  assign cfg_step = step;

  always_comb begin
    busy_fall = busy_q && !i2c_busy;
    timed_out = 1'b0;
    // A handshake arriving on the expiry cycle still wins over the timeout.
    if (state == ST_REQ) begin
      timed_out = (timer == TOUT_LAST) && !i2c_busy;
    end
    if (state == ST_WAIT) begin
      timed_out = (timer == TOUT_LAST) && !busy_fall;
    end
`ifdef CODEC_CFG_RETRY_EN
    exhausted = (state == ST_RETRY) && (retry >= 4'(MAX_RETRY));
`else
    exhausted = (state == ST_RETRY);
`endif
    fail_evt = timed_out || exhausted;
  end

  always_ff @(posedge i2c_clock_50) begin
    if (rst_i) begin
      state         <= ST_INIT;
      step          <= 4'd0;
      timer         <= 20'd0;
      busy_q        <= 1'b0;
      seen_done     <= 1'b0;
      usr_txn       <= 1'b0;
      usr_ack       <= 1'b0;
      i2c_data      <= 16'h0000;
      i2c_send_flag <= 1'b0;
      cfg_busy      <= 1'b0;
      cfg_done      <= 1'b0;
      cfg_error     <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
      retry         <= 4'd0;
      resend        <= 1'b0;
`endif
    end else begin
      busy_q  <= i2c_busy;
      usr_ack <= 1'b0;
      if (fail_evt) begin
        // Table failures are sticky errors; user failures just complete the handshake.
        i2c_send_flag <= 1'b0;
        timer         <= 20'd0;
        if (usr_txn) begin
          usr_ack <= 1'b1;
          usr_txn <= 1'b0;
          state   <= ST_DONE;
        end else begin
          cfg_error <= 1'b1;
          cfg_busy  <= 1'b0;
          state     <= ST_ERROR;
        end
      end else begin
        case (state)
          ST_INIT: begin
            // The controller is not reset with us; let an in-flight write finish.
            if (!i2c_busy) begin
              cfg_busy <= 1'b1;
              step     <= 4'd0;
              timer    <= 20'd0;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (!usr_txn) begin
              i2c_data <= rom_word;
            end
            i2c_send_flag <= 1'b1;
            seen_done     <= 1'b0;
            timer         <= 20'd0;
            state         <= ST_REQ;
          end
          ST_REQ: begin
            // Flag is a level: the controller only samples it on its SCL phase.
            if (i2c_busy) begin
              i2c_send_flag <= 1'b0;
              timer         <= 20'd0;
              state         <= ST_WAIT;
            end else begin
              timer <= timer + 20'd1;
            end
          end
          ST_WAIT: begin
            if (i2c_done) begin
              seen_done <= 1'b1;
            end
            if (busy_fall) begin
              timer <= 20'd0;
              if (seen_done || i2c_done) begin
                usr_ack <= usr_txn;
                state   <= ST_GAP;
              end else begin
                state <= ST_RETRY;
              end
            end else begin
              timer <= timer + 20'd1;
            end
          end
          ST_RETRY: begin
`ifdef CODEC_CFG_RETRY_EN
            retry  <= retry + 4'd1;
            resend <= 1'b1;
`endif
            timer <= 20'd0;
            state <= ST_GAP;
          end
          ST_GAP: begin
            if (timer == GAP_LAST) begin
              timer <= 20'd0;
`ifdef CODEC_CFG_RETRY_EN
              if (resend) begin
                resend <= 1'b0;
                state  <= ST_LOAD;
              end else
`endif
              if (usr_txn) begin
                usr_txn <= 1'b0;
                state   <= ST_DONE;
              end else if (step == LAST_STEP) begin
                cfg_busy <= 1'b0;
                cfg_done <= 1'b1;
                state    <= ST_DONE;
              end else begin
                step  <= step + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
                retry <= 4'd0;
`endif
                state <= ST_LOAD;
              end
            end else begin
              timer <= timer + 20'd1;
            end
          end
          ST_DONE, ST_ERROR: begin
            if (cfg_start) begin
              cfg_done  <= 1'b0;
              cfg_error <= 1'b0;
              cfg_busy  <= 1'b1;
              step      <= 4'd0;
              timer     <= 20'd0;
`ifdef CODEC_CFG_RETRY_EN
              retry     <= 4'd0;
`endif
              state     <= ST_LOAD;
            end else if (state == ST_DONE && usr_req && !usr_ack) begin
              // usr_ack high means the requester has not yet dropped usr_req.
              i2c_data      <= usr_data;
              usr_txn       <= 1'b1;
              i2c_send_flag <= 1'b1;
              seen_done     <= 1'b0;
              timer         <= 20'd0;
`ifdef CODEC_CFG_RETRY_EN
              retry         <= 4'd0;
`endif
              state         <= ST_REQ;
            end
          end
          default: begin
            state <= ST_INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb/tb_codec_cfg_seq.sv - directed self-checking bench for codec_cfg_seq with an I2C controller model
module tb_codec_cfg_seq;

  localparam int GAP      = 16;
  localparam int TMO      = 300;
  localparam int BUSY_LEN = 6;
`ifdef CODEC_CFG_RETRY_EN
  localparam int ATTEMPTS = 4;
`else
  localparam int ATTEMPTS = 1;
`endif
  localparam bit RETRY_ON = (ATTEMPTS > 1);

  logic        i2c_clock_50 = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_start = 1'b0;
  logic        usr_req = 1'b0;
  logic [15:0] usr_data = 16'h0000;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        usr_ack;
  logic [7:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        i2c_send_flag;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_error;
  logic [3:0]  cfg_step;

  logic [15:0] exp_tab [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
                                16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] nack_word = 16'hFFFF;
  int          nack_left = 0;
  bit          never_busy = 0;
  bit          coincide = 0;
  int          busy_len = BUSY_LEN;
  logic [15:0] sent_q [$];
  int          lat_q [$];
  int          fall_cyc = -1;
  int          rise_cyc = 0;
  bit          flag_prev = 0;
  int          n_ack = 0;

  codec_cfg_seq #(
    .DEV_ADDR   (8'h34),
    .N_REGS     (11),
    .MAX_RETRY  (3),
    .TIMEOUT    (20'(TMO)),
    .GAP_CYCLES (GAP)
  ) dut (
    .i2c_clock_50  (i2c_clock_50),
    .rst_i         (rst_i),
    .cfg_start     (cfg_start),
    .usr_req       (usr_req),
    .usr_data      (usr_data),
    .usr_ack       (usr_ack),
    .i2c_busy      (i2c_busy),
    .i2c_done      (i2c_done),
    .i2c_addr      (i2c_addr),
    .i2c_data      (i2c_data),
    .i2c_send_flag (i2c_send_flag),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_error     (cfg_error),
    .cfg_step      (cfg_step)
  );

  always #10 i2c_clock_50 = ~i2c_clock_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_word(input logic [15:0] w);
    int c = 0;
    foreach (sent_q[i]) if (sent_q[i] == w) c++;
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge i2c_clock_50);
    #1;
  endtask

  task automatic start_run(input string tag);
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    check_eq({tag, "_busy"}, 32'(cfg_busy), 1);
    check_eq({tag, "_done_clr"}, 32'(cfg_done), 0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (cfg_busy && n < budget) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_finished"}, 32'(cfg_busy), 0);
  endtask

  task automatic user_write(input logic [15:0] w, input int budget);
    int n = 0;
    usr_data = w;
    usr_req  = 1'b1;
    while (!usr_ack && n < budget) begin
      tick(1);
      n++;
    end
    usr_req = 1'b0;
    check_eq("usr_ack_seen", 32'(usr_ack), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_flag"}, 32'(i2c_send_flag), 0);
    check_eq({tag, "_data"}, 32'(i2c_data), 0);
    check_eq({tag, "_busy"}, 32'(cfg_busy), 0);
    check_eq({tag, "_done"}, 32'(cfg_done), 0);
    check_eq({tag, "_error"}, 32'(cfg_error), 0);
    check_eq({tag, "_ack"}, 32'(usr_ack), 0);
    check_eq({tag, "_step"}, 32'(cfg_step), 0);
  endtask

  // I2C controller model: accepts the flag, holds busy, ACKs via a done pulse
  // (before or together with the busy fall) unless told to NACK a given word.
  initial begin : i2c_model
    bit ack;
    forever begin
      @(posedge i2c_clock_50);
      #1;
      if (i2c_send_flag && !never_busy) begin
        sent_q.push_back(i2c_data);
        ack = !(i2c_data == nack_word && nack_left > 0);
        if (!ack) nack_left--;
        i2c_busy = 1'b1;
        repeat (busy_len) @(posedge i2c_clock_50);
        #1;
        if (ack && !coincide) begin
          i2c_done = 1'b1;
          @(posedge i2c_clock_50);
          #1;
          i2c_done = 1'b0;
        end
        if (ack && coincide) i2c_done = 1'b1;
        i2c_busy = 1'b0;
        fall_cyc = cyc;
        @(posedge i2c_clock_50);
        #1;
        i2c_done = 1'b0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge i2c_clock_50);
      cyc++;
      #1;
      if (i2c_send_flag && !flag_prev) begin
        rise_cyc = cyc;
        if (fall_cyc >= 0) lat_q.push_back(cyc - fall_cyc);
      end
      flag_prev = i2c_send_flag;
      if (usr_ack) n_ack++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int base;
    int ack0;
    int bad_lat;
    int err_cyc;

    // Reset state
    tick(3);
    check_reset_outputs("rst");
    check_eq("rst_addr", 32'(i2c_addr), 32'h34);

    // Run 1: every write ACKed
    sent_q.delete();
    lat_q.delete();
    rst_i = 1'b0;
    tick(1);
    check_eq("init_busy", 32'(cfg_busy), 1);
    wait_idle("run1", 3000);
    check_eq("run1_done", 32'(cfg_done), 1);
    check_eq("run1_error", 32'(cfg_error), 0);
    check_eq("run1_step", 32'(cfg_step), 10);
    check_eq("run1_nsent", 32'(sent_q.size()), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < sent_q.size()) check_eq($sformatf("run1_word%0d", i), 32'(sent_q[i]), 32'(exp_tab[i]));
    end
    check_eq("run1_nlat", 32'(lat_q.size()), 10);
    bad_lat = 0;
    foreach (lat_q[i]) if (lat_q[i] != GAP + 2) bad_lat++;
    check_eq("run1_gap_latency", 32'(bad_lat), 0);

    // Run 2: step 3 NACKed twice, 1-cycle busy, done coinciding with busy fall
    sent_q.delete();
    nack_word = 16'h0479;
    nack_left = 2;
    busy_len  = 1;
    coincide  = 1;
    start_run("run2");
    wait_idle("run2", 3000);
    check_eq("run2_count_0479", 32'(count_word(16'h0479)), RETRY_ON ? 3 : 1);
    check_eq("run2_nsent", 32'(sent_q.size()), RETRY_ON ? 13 : 4);
    check_eq("run2_error", 32'(cfg_error), RETRY_ON ? 0 : 1);
    check_eq("run2_done", 32'(cfg_done), RETRY_ON ? 1 : 0);
    check_eq("run2_step", 32'(cfg_step), RETRY_ON ? 10 : 3);

    // Run 3: step 5 NACKed on every attempt
    sent_q.delete();
    nack_word = 16'h0812;
    nack_left = 1000;
    busy_len  = BUSY_LEN;
    coincide  = 0;
    start_run("run3");
    wait_idle("run3", 3000);
    check_eq("run3_attempts", 32'(count_word(16'h0812)), ATTEMPTS);
    check_eq("run3_nsent", 32'(sent_q.size()), 5 + ATTEMPTS);
    check_eq("run3_error", 32'(cfg_error), 1);
    check_eq("run3_done", 32'(cfg_done), 0);
    check_eq("run3_step", 32'(cfg_step), 5);
    nack_left = 0;

    // usr_req is held off while in ERROR
    base = sent_q.size();
    ack0 = n_ack;
    usr_data = 16'h0465;
    usr_req  = 1'b1;
    tick(40);
    usr_req = 1'b0;
    check_eq("err_usr_nsent", 32'(sent_q.size()), 32'(base));
    check_eq("err_usr_noack", 32'(n_ack - ack0), 0);

    // Run 4: controller never raises busy
    sent_q.delete();
    never_busy = 1;
    start_run("run4");
    n = 0;
    while (!cfg_error && n < TMO + 50) begin
      tick(1);
      n++;
    end
    err_cyc = cyc;
    check_eq("tmo_error", 32'(cfg_error), 1);
    check_eq("tmo_cycles", 32'(err_cyc - rise_cyc), TMO);
    check_eq("tmo_flag", 32'(i2c_send_flag), 0);
    check_eq("tmo_step", 32'(cfg_step), 0);
    check_eq("tmo_nsent", 32'(sent_q.size()), 0);
    never_busy = 0;

    // Run 5: clean run with an ignored mid-run cfg_start, then runtime writes
    sent_q.delete();
    start_run("run5");
    tick(100);
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
    wait_idle("run5", 3000);
    check_eq("run5_nsent", 32'(sent_q.size()), 11);
    check_eq("run5_done", 32'(cfg_done), 1);

    base = sent_q.size();
    ack0 = n_ack;
    user_write(16'h0465, 500);
    tick(GAP + 20);
    check_eq("usr_nsent", 32'(sent_q.size()), 32'(base + 1));
    if (sent_q.size() > 0) check_eq("usr_word", 32'(sent_q[sent_q.size() - 1]), 32'h0465);
    check_eq("usr_ack_pulses", 32'(n_ack - ack0), 1);
    check_eq("usr_done_kept", 32'(cfg_done), 1);
    check_eq("usr_busy_low", 32'(cfg_busy), 0);

    nack_word = 16'h0A55;
    nack_left = 1000;
    ack0 = n_ack;
    user_write(16'h0A55, 2000);
    tick(GAP + 20);
    nack_left = 0;
    check_eq("usr_nack_attempts", 32'(count_word(16'h0A55)), ATTEMPTS);
    check_eq("usr_nack_ack_pulses", 32'(n_ack - ack0), 1);
    check_eq("usr_nack_no_error", 32'(cfg_error), 0);
    check_eq("usr_nack_done_kept", 32'(cfg_done), 1);

    // Run 6: reset during WAIT of step 4
    sent_q.delete();
    start_run("run6");
    n = 0;
    while (sent_q.size() < 5 && n < 2000) begin
      tick(1);
      n++;
    end
    check_eq("run6_reached_step4", 32'(sent_q.size()), 5);
    tick(2);
    rst_i = 1'b1;
    sent_q.delete();
    tick(1);
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    tick(1);
    check_eq("midrst_init_hold_busy", 32'(cfg_busy), 0);
    check_eq("midrst_init_hold_flag", 32'(i2c_send_flag), 0);
    n = 0;
    while (!cfg_busy && n < 100) begin
      tick(1);
      n++;
    end
    wait_idle("run6", 3000);
    check_eq("run6_nsent", 32'(sent_q.size()), 11);
    if (sent_q.size() > 0) check_eq("run6_first_word", 32'(sent_q[0]), 32'h1E00);
    check_eq("run6_done", 32'(cfg_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
